// File: rtl/axi_burst_copy_dma.sv
// rtl/axi_burst_copy_dma.sv - AXI4 burst-copy DMA master with internal burst buffer
//
// Copies len_words full-width words from src_addr to dst_addr. Each burst
// (at most MAX_BURST beats) is read into a local buffer, then written back
// out. Only one AXI transaction is outstanding at a time.
//
// Optional feature macro: DMA_RESP_CHECK_EN
//   defined   : non-OKAY rresp/bresp or a misplaced rlast sets err; the copy
//               stops after the current burst's write response.
//   undefined : responses and IDs are ignored, err stays 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    1-cycle request, honoured only when idle
//   src_addr, dst_addr       byte addresses (forced to word alignment)
//   len_words                number of words to copy (0 = no-op)
//   busy, done, err          status: busy window, completion pulse, sticky error
//   aw*/w*/b*/ar*/r*         AXI4 master channels (INCR, full-width beats)

module axi_burst_copy_dma #(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int MAX_BURST      = 16,
  parameter int AXI_ID         = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [AXI_ADDR_WIDTH-1:0] src_addr,
  input  logic [AXI_ADDR_WIDTH-1:0] dst_addr,
  input  logic [15:0]               len_words,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [AXI_ID_WIDTH-1:0]   awid,
  output logic [AXI_ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]                awlen,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [AXI_DATA_WIDTH-1:0] wdata,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [AXI_ID_WIDTH-1:0]   bid,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  output logic [AXI_ID_WIDTH-1:0]   arid,
  output logic [AXI_ADDR_WIDTH-1:0] araddr,
  output logic [7:0]                arlen,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [AXI_ID_WIDTH-1:0]   rid,
  input  logic [AXI_DATA_WIDTH-1:0] rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  input  logic                      rlast,
  output logic                      rready
);

  localparam int BYTES_PER_WORD = AXI_DATA_WIDTH / 8;
  localparam int BYTE_SHIFT     = $clog2(BYTES_PER_WORD);
  localparam int IDX_W          = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [8:0] MAX_BLEN = 9'(MAX_BURST);
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = {AXI_ADDR_WIDTH{1'b1}} << BYTE_SHIFT;

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_t;

  state_t                    state;
  logic [AXI_ADDR_WIDTH-1:0] cur_src;
  logic [AXI_ADDR_WIDTH-1:0] cur_dst;
  logic [15:0]               remaining;
  logic [8:0]                blen;
  logic [8:0]                beat;
  logic [AXI_DATA_WIDTH-1:0] burst_buf [MAX_BURST];

  assign awid = AXI_ID_WIDTH'(AXI_ID);
  assign arid = AXI_ID_WIDTH'(AXI_ID);

  function automatic logic [8:0] burst_len(input logic [15:0] rem);
    return (rem > 16'(MAX_BURST)) ? MAX_BLEN : rem[8:0];
  endfunction

  // Bookkeeping for the end of the current burst (used in the B phase).
  logic [15:0]               rem_after;
  logic [AXI_ADDR_WIDTH-1:0] addr_step;
  logic [AXI_ADDR_WIDTH-1:0] src_next;
  logic [AXI_ADDR_WIDTH-1:0] dst_next;
  logic [8:0]                next_beat;
  logic [8:0]                blen_after;

  assign rem_after  = remaining - 16'(blen);
  assign addr_step  = AXI_ADDR_WIDTH'(blen) << BYTE_SHIFT;
  assign src_next   = cur_src + addr_step;
  assign dst_next   = cur_dst + addr_step;
  assign next_beat  = beat + 9'd1;
  assign blen_after = burst_len(rem_after);

  // Response qualification; constant 0 when checking is compiled out.
  logic r_bad;
  logic b_bad;
`ifdef DMA_RESP_CHECK_EN
  // rlast must arrive exactly on beat blen-1: early, missing or extra all count.
  assign r_bad = (rresp != 2'b00) ||
                 (rlast && (beat != blen - 9'd1)) ||
                 (!rlast && (beat == blen - 9'd1));
  assign b_bad = (bresp != 2'b00);
`else
  assign r_bad = 1'b0;
  assign b_bad = 1'b0;
`endif

  logic unused_sink;
  assign unused_sink = ^{rid, bid, rresp, bresp};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      wlast     <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awaddr    <= '0;
      araddr    <= '0;
      awlen     <= '0;
      arlen     <= '0;
      wdata     <= '0;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      blen      <= '0;
      beat      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_src   <= src_addr & ALIGN_MASK;
            cur_dst   <= dst_addr & ALIGN_MASK;
            remaining <= len_words;
            err       <= 1'b0;
            busy      <= 1'b1;
            if (len_words == 16'd0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              blen    <= burst_len(len_words);
              arlen   <= 8'(burst_len(len_words) - 9'd1);
              araddr  <= src_addr & ALIGN_MASK;
              arvalid <= 1'b1;
              state   <= S_AR;
            end
          end
        end

        S_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            beat    <= '0;
            state   <= S_R;
          end
        end

        S_R: begin
          if (rvalid) begin
            // Beats past blen are accepted but not stored.
            if (beat < blen) begin
              burst_buf[beat[IDX_W-1:0]] <= rdata;
              beat <= next_beat;
            end
            if (r_bad) begin
              err <= 1'b1;
            end
            if (rlast) begin
              rready  <= 1'b0;
              awaddr  <= cur_dst;
              awlen   <= arlen;
              awvalid <= 1'b1;
              state   <= S_AW;
            end
          end
        end

        S_AW: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            wdata   <= burst_buf[0];
            wlast   <= (blen == 9'd1);
            beat    <= '0;
            state   <= S_W;
          end
        end

        S_W: begin
          // wdata/wlast only change on an accepted beat, so they hold under stall.
          if (wready) begin
            if (wlast) begin
              wvalid <= 1'b0;
              wlast  <= 1'b0;
              bready <= 1'b1;
              state  <= S_B;
            end else begin
              beat  <= next_beat;
              wdata <= burst_buf[next_beat[IDX_W-1:0]];
              wlast <= (next_beat == blen - 9'd1);
            end
          end
        end

        S_B: begin
          if (bvalid) begin
            bready    <= 1'b0;
            remaining <= rem_after;
            cur_src   <= src_next;
            cur_dst   <= dst_next;
            if (b_bad) begin
              err <= 1'b1;
            end
            if ((rem_after == 16'd0) || err || b_bad) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              blen    <= blen_after;
              arlen   <= 8'(blen_after - 9'd1);
              araddr  <= src_next;
              arvalid <= 1'b1;
              state   <= S_AR;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_copy_dma.sv
// tb/tb_axi_burst_copy_dma.sv - directed bench for axi_burst_copy_dma with an AXI RAM slave model

module tb_axi_burst_copy_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len_words = '0;
  logic        busy, done, err;
  logic [3:0]  awid, arid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic        awvalid, wvalid, wlast, bready, arvalid, rready;
  logic [63:0] wdata;
  logic        awready = 1'b0;
  logic        wready = 1'b0;
  logic        arready = 1'b0;
  logic        bvalid = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rlast = 1'b0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic [3:0]  bid = 4'd0;
  logic [3:0]  rid = 4'd0;

  axi_burst_copy_dma dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
    .busy(busy), .done(done), .err(err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready)
  );

  always #5 clk = ~clk;

  // ---------------- AXI RAM slave model ----------------
  logic [63:0] mem [0:511];
  logic [8:0]  rd_word, wr_word;
  logic [8:0]  rd_left;
  logic        aw_have, b_pend;
  bit          stall_en = 1'b0;
  int          sl_b_cnt = 0;
  int          bresp_bad_at = -1;

  function automatic bit gate();
    return stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  function automatic logic [63:0] pat(input int i);
    return {32'hA0A0_A0A0, 32'(i)};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      arready <= 1'b0; rvalid <= 1'b0; rlast <= 1'b0; rd_left <= '0; rd_word <= '0;
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; aw_have <= 1'b0; b_pend <= 1'b0;
      wr_word <= '0;
    end else begin
      if (arvalid && arready) begin
        rd_word <= araddr[11:3];
        rd_left <= {1'b0, arlen} + 9'd1;
        arready <= 1'b0;
      end else begin
        arready <= (rd_left == 9'd0 && !rvalid) ? gate() : 1'b0;
      end
      if (!rvalid || rready) begin
        if (rd_left != 9'd0 && gate()) begin
          rvalid  <= 1'b1;
          rdata   <= mem[rd_word];
          rlast   <= (rd_left == 9'd1);
          rresp   <= 2'b00;
          rd_word <= rd_word + 9'd1;
          rd_left <= rd_left - 9'd1;
        end else begin
          rvalid <= 1'b0;
          rlast  <= 1'b0;
        end
      end
      if (awvalid && awready) begin
        wr_word <= awaddr[11:3];
        aw_have <= 1'b1;
        awready <= 1'b0;
      end else begin
        awready <= (!aw_have && !b_pend) ? gate() : 1'b0;
      end
      wready <= aw_have ? gate() : 1'b0;
      if (wvalid && wready && aw_have) begin
        mem[wr_word] <= wdata;
        wr_word <= wr_word + 9'd1;
        if (wlast) begin
          aw_have <= 1'b0;
          b_pend  <= 1'b1;
        end
      end
      if (bvalid && bready) begin
        bvalid   <= 1'b0;
        b_pend   <= 1'b0;
        sl_b_cnt <= sl_b_cnt + 1;
      end else if (b_pend && !bvalid && gate()) begin
        bvalid <= 1'b1;
        bresp  <= (sl_b_cnt == bresp_bad_at) ? 2'b10 : 2'b00;
      end
    end
  end

  // ---------------- channel monitor (samples on negedge) ----------------
  int          ar_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0, done_cnt = 0;
  int          any_valid = 0, stab_err = 0;
  logic [7:0]  arlen_log [64];
  logic [7:0]  awlen_log [64];
  logic [31:0] araddr_log [64];
  logic [31:0] awaddr_log [64];
  bit          prev_ar_wait = 0, prev_aw_wait = 0, prev_w_wait = 0;
  logic [31:0] prev_araddr, prev_awaddr;
  logic [63:0] prev_wdata;
  logic        prev_wlast;

  always @(negedge clk) begin
    if (rst) begin
      prev_ar_wait = 0; prev_aw_wait = 0; prev_w_wait = 0;
    end else begin
      if (arvalid || awvalid || wvalid) any_valid++;
      if (prev_ar_wait && (!arvalid || araddr != prev_araddr)) stab_err++;
      if (prev_aw_wait && (!awvalid || awaddr != prev_awaddr)) stab_err++;
      if (prev_w_wait && (!wvalid || wdata != prev_wdata || wlast != prev_wlast)) stab_err++;
      prev_ar_wait = arvalid && !arready; prev_araddr = araddr;
      prev_aw_wait = awvalid && !awready; prev_awaddr = awaddr;
      prev_w_wait = wvalid && !wready; prev_wdata = wdata; prev_wlast = wlast;
      if (arvalid && arready) begin
        if (ar_hs < 64) begin arlen_log[ar_hs] = arlen; araddr_log[ar_hs] = araddr; end
        ar_hs++;
      end
      if (awvalid && awready) begin
        if (aw_hs < 64) begin awlen_log[aw_hs] = awlen; awaddr_log[aw_hs] = awaddr; end
        aw_hs++;
      end
      if (wvalid && wready) w_hs++;
      if (bvalid && bready) b_hs++;
      if (done) done_cnt++;
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] n, input int limit);
    int base;
    int c;
    base = done_cnt;
    @(negedge clk);
    src_addr = s; dst_addr = d; len_words = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    #1;
    while (done_cnt == base && c < limit) begin
      @(negedge clk); #1;
      c++;
    end
    @(negedge clk); #1;
    check_eq({tag, "_done_pulses"}, 64'(done_cnt - base), 64'd1);
    check_eq({tag, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  task automatic check_region(input string tag, input int s_word, input int d_word, input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) if (mem[d_word + k] !== pat(s_word + k)) bad++;
    check_eq({tag, "_data_mismatches"}, 64'(bad), 64'd0);
  endtask

  initial begin
    int a0, w0, b0, v0, c;
    for (int i = 0; i < 512; i++) mem[i] = (i < 256) ? pat(i) : 64'h0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_valids", 64'({arvalid, awvalid, wvalid, wlast, rready, bready}), 64'd0);
    check_eq("rst_addrs", {awaddr, araddr}, 64'd0);

    // 1: single 4-word burst, word 0 -> word 32
    a0 = ar_hs; w0 = aw_hs;
    run_copy("t1", 32'h000, 32'h100, 16'd4, 500);
    check_eq("t1_ar_count", 64'(ar_hs - a0), 64'd1);
    check_eq("t1_aw_count", 64'(aw_hs - w0), 64'd1);
    check_eq("t1_arlen", 64'(arlen_log[a0]), 64'd3);
    check_eq("t1_awlen", 64'(awlen_log[w0]), 64'd3);
    check_eq("t1_mem32", mem[32], pat(0));
    check_eq("t1_mem35", mem[35], pat(3));

    // 2: 40 words -> bursts 16,16,8
    a0 = ar_hs; w0 = aw_hs; b0 = b_hs;
    run_copy("t2", 32'h400, 32'h800, 16'd40, 2000);
    check_eq("t2_ar_count", 64'(ar_hs - a0), 64'd3);
    check_eq("t2_b_count", 64'(b_hs - b0), 64'd3);
    check_eq("t2_arlens", {40'd0, arlen_log[a0], arlen_log[a0+1], arlen_log[a0+2]}, 64'h0F0F07);
    check_eq("t2_awlens", {40'd0, awlen_log[w0], awlen_log[w0+1], awlen_log[w0+2]}, 64'h0F0F07);
    check_eq("t2_araddr2", 64'(araddr_log[a0+2]), 64'h500);
    check_eq("t2_awaddr1", 64'(awaddr_log[w0+1]), 64'h880);
    check_eq("t2_awaddr2", 64'(awaddr_log[w0+2]), 64'h900);
    check_region("t2", 128, 256, 40);
    check_eq("t2_err", 64'(err), 64'd0);

    // 3: zero-length copy
    v0 = any_valid; c = done_cnt;
    @(negedge clk);
    src_addr = 32'h40; dst_addr = 32'h140; len_words = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_eq("t3_done_next", 64'(done), 64'd1);
    check_eq("t3_busy_in_done", 64'(busy), 64'd1);
    @(negedge clk); #1;
    check_eq("t3_done_cleared", 64'(done), 64'd0);
    check_eq("t3_busy_low", 64'(busy), 64'd0);
    check_eq("t3_done_pulses", 64'(done_cnt - c), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    check_eq("t3_no_valids", 64'(any_valid - v0), 64'd0);

    // 4: random stalls on every slave handshake
    stall_en = 1'b1;
    stab_err = 0;
    run_copy("t4", 32'h600, 32'hA00, 16'd20, 3000);
    check_region("t4", 192, 320, 20);
    check_eq("t4_stable", 64'(stab_err), 64'd0);
    stall_en = 1'b0;

    // 5: reset during W beat 5 of 16, then a fresh 2-word copy
    w0 = w_hs;
    @(negedge clk);
    src_addr = 32'h000; dst_addr = 32'h300; len_words = 16'd16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    #1;
    while ((w_hs - w0) < 5 && c < 500) begin
      @(negedge clk); #1;
      c++;
    end
    check_eq("t5_reached_beat5", 64'(w_hs - w0), 64'd5);
    rst = 1'b1;
    @(negedge clk); #1;
    check_eq("t5_valids_after_rst", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'd0);
    check_eq("t5_busy_after_rst", 64'(busy), 64'd0);
    rst = 1'b0;
    run_copy("t5b", 32'h020, 32'hC80, 16'd2, 500);
    check_region("t5b", 4, 400, 2);

`ifdef DMA_RESP_CHECK_EN
    // 6: error response on the first of three bursts aborts the copy
    a0 = ar_hs; b0 = b_hs;
    bresp_bad_at = sl_b_cnt;
    run_copy("t6", 32'h080, 32'hDC0, 16'd40, 2000);
    check_eq("t6_err", 64'(err), 64'd1);
    check_eq("t6_ar_count", 64'(ar_hs - a0), 64'd1);
    check_eq("t6_b_count", 64'(b_hs - b0), 64'd1);
    bresp_bad_at = -1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
